sc_display_sequencer: RTL and testbench

Game-flow controller that drives the select input of the 8-bit display multiplexer. It chooses among three sources: game data (select 0), all-ones fill (select 1) and pseudo-random pattern (select 2). It also generates the random pattern itself. It sits between the frame-tick prescaler, the game-logic event pulses and the display mux, and sequences attract, ready, play, crash-flash and game-over screens.

---
 rtl/sc_display_sequencer.sv | 137 +++++++++++++
 tb/tb_sc_display_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_display_sequencer.sv
// Game-flow sequencer: drives the display-mux select code and generates the 8-bit pattern LFSR.
// Defining DSEQ_PAUSE_EN adds the pause input and the PAUSE screen.
module sc_display_sequencer #(
  parameter int DSEQ_SELECTWIDTH  = 8,
  parameter int DSEQ_DATAWIDTH    = 8,
  parameter int DSEQ_READY_FRAMES = 4,
  parameter int DSEQ_CRASH_FRAMES = 6,
  parameter int DSEQ_LIVES        = 3
) (
  input  logic                        SC_DSEQ_CLOCK_50,
  input  logic                        SC_DSEQ_RESET_InHigh,
  input  logic                        SC_DSEQ_tick_In,
  input  logic                        SC_DSEQ_start_In,
  input  logic                        SC_DSEQ_crash_In,
`ifdef DSEQ_PAUSE_EN
  input  logic                        SC_DSEQ_pause_In,
`endif
  output logic [DSEQ_SELECTWIDTH-1:0] SC_DSEQ_select_OutBus,
  output logic [DSEQ_DATAWIDTH-1:0]   SC_DSEQ_random_OutBus,
  output logic [2:0]                  SC_DSEQ_state_OutBus,
  output logic [2:0]                  SC_DSEQ_lives_OutBus,
  output logic                        SC_DSEQ_playing_Out
);

  localparam logic [2:0] ATTRACT = 3'd0;
  localparam logic [2:0] READY   = 3'd1;
  localparam logic [2:0] PLAY    = 3'd2;
  localparam logic [2:0] CRASH   = 3'd3;
  localparam logic [2:0] OVER    = 3'd4;
  localparam logic [2:0] PAUSE   = 3'd5;

  localparam logic [7:0] READY_LAST = 8'(DSEQ_READY_FRAMES - 1);
  localparam logic [7:0] CRASH_LAST = 8'(DSEQ_CRASH_FRAMES - 1);
  localparam logic [2:0] LIVES_INIT = 3'(DSEQ_LIVES);

  logic [2:0] stateReg, stateNext;
  logic [7:0] counterReg, counterNext;
  logic [2:0] livesReg, livesNext;
  logic [7:0] lfsrReg, lfsrNext;
  logic [1:0] selectReg, selectNext;
  logic       playingReg, playingNext;
  logic       pauseEvt;
  logic       tickLive;

`ifdef DSEQ_PAUSE_EN
  assign pauseEvt = SC_DSEQ_pause_In;
`else
  assign pauseEvt = 1'b0;
`endif

  function automatic logic [7:0] lfsrStep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // State register: every output is a register loaded from the decoded next values
  always_ff @(posedge SC_DSEQ_CLOCK_50) begin
    if (SC_DSEQ_RESET_InHigh) begin
      stateReg   <= ATTRACT;
      counterReg <= '0;
      livesReg   <= LIVES_INIT;
      lfsrReg    <= 8'hA5;
      selectReg  <= 2'd2;
      playingReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      counterReg <= counterNext;
      livesReg   <= livesNext;
      lfsrReg    <= lfsrNext;
      selectReg  <= selectNext;
      playingReg <= playingNext;
    end
  end

  // Next-state logic; PAUSE freezes both the frame counter and the LFSR
  always_comb begin
    stateNext = stateReg;
    livesNext = livesReg;
    tickLive  = SC_DSEQ_tick_In && (stateReg != PAUSE);
    unique case (stateReg)
      ATTRACT, OVER: begin
        if (SC_DSEQ_start_In) begin
          stateNext = READY;
          livesNext = LIVES_INIT;
        end
      end
      READY: begin
        if (SC_DSEQ_tick_In && counterReg == READY_LAST) stateNext = PLAY;
      end
      PLAY: begin
        if (SC_DSEQ_crash_In) begin
          stateNext = CRASH;
          livesNext = (livesReg != 3'd0) ? livesReg - 3'd1 : 3'd0;
        end else if (pauseEvt) begin
          stateNext = PAUSE;
        end
      end
      CRASH: begin
        if (SC_DSEQ_tick_In && counterReg == CRASH_LAST)
          stateNext = (livesReg == 3'd0) ? OVER : PLAY;
      end
      PAUSE: begin
        if (pauseEvt) stateNext = PLAY;
      end
      default: stateNext = ATTRACT;
    endcase
    // A state change always restarts the frame count, even if a tick arrives alongside
    counterNext = (stateNext != stateReg) ? 8'd0 : counterReg + {7'd0, tickLive};
    lfsrNext    = tickLive ? lfsrStep(lfsrReg) : lfsrReg;
  end

  // Output decode from the values about to be registered
  always_comb begin
    selectNext  = 2'd1;
    playingNext = 1'b0;
    unique case (stateNext)
      ATTRACT: selectNext = 2'd2;
      PLAY: begin
        selectNext  = 2'd0;
        playingNext = 1'b1;
      end
      CRASH:   selectNext = counterNext[0] ? 2'd0 : 2'd1;
      default: selectNext = 2'd1;
    endcase
  end

  always_comb begin
    SC_DSEQ_select_OutBus      = '0;
    SC_DSEQ_select_OutBus[1:0] = selectReg;
    SC_DSEQ_random_OutBus      = '0;
    SC_DSEQ_random_OutBus[7:0] = lfsrReg;
  end

  assign SC_DSEQ_state_OutBus = stateReg;
  assign SC_DSEQ_lives_OutBus = livesReg;
  assign SC_DSEQ_playing_Out  = playingReg;

endmodule

// File: tb/tb_sc_display_sequencer.sv
// Directed bench for sc_display_sequencer: a reference model pushes expected outputs to a
// scoreboard queue each cycle; the DUT response is popped and compared one cycle later.
module tb_sc_display_sequencer;
  localparam int LIVES  = 3;
  localparam int READYF = 4;
  localparam int CRASHF = 6;

  logic       clk = 1'b0;
  logic       rst, tick, start, crash;
`ifdef DSEQ_PAUSE_EN
  logic       pause;
`endif
  logic [7:0] sel, rnd;
  logic [2:0] st, lv;
  logic       play;

  always #5 clk = ~clk;

  sc_display_sequencer #(
    .DSEQ_SELECTWIDTH(8), .DSEQ_DATAWIDTH(8), .DSEQ_READY_FRAMES(READYF),
    .DSEQ_CRASH_FRAMES(CRASHF), .DSEQ_LIVES(LIVES)
  ) dut (
    .SC_DSEQ_CLOCK_50(clk),
    .SC_DSEQ_RESET_InHigh(rst),
    .SC_DSEQ_tick_In(tick),
    .SC_DSEQ_start_In(start),
    .SC_DSEQ_crash_In(crash),
`ifdef DSEQ_PAUSE_EN
    .SC_DSEQ_pause_In(pause),
`endif
    .SC_DSEQ_select_OutBus(sel),
    .SC_DSEQ_random_OutBus(rnd),
    .SC_DSEQ_state_OutBus(st),
    .SC_DSEQ_lives_OutBus(lv),
    .SC_DSEQ_playing_Out(play)
  );

  typedef struct {
    logic [7:0] st;
    logic [7:0] sel;
    logic [7:0] rnd;
    logic [7:0] lv;
    logic [7:0] play;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  bit [2:0] mSt;
  bit [7:0] mCnt, mLfsr;
  bit [2:0] mLv;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [7:0] modelSel();
    case (mSt)
      3'd0: return 8'd2;
      3'd2: return 8'd0;
      3'd3: return mCnt[0] ? 8'd0 : 8'd1;
      default: return 8'd1;
    endcase
  endfunction

  task automatic modelStep(input bit tk, input bit s, input bit c, input bit p, input bit r);
    bit [2:0] ns;
    bit [7:0] nc;
    bit live;
    if (r) begin
      mSt = 3'd0; mCnt = 8'd0; mLv = 3'(LIVES); mLfsr = 8'hA5;
      return;
    end
    live = tk && (mSt != 3'd5);
    ns = mSt;
    nc = mCnt + (live ? 8'd1 : 8'd0);
    if (live) mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
    case (mSt)
      3'd0, 3'd4: if (s) begin ns = 3'd1; mLv = 3'(LIVES); end
      3'd1: if (tk && mCnt == 8'(READYF - 1)) ns = 3'd2;
      3'd2: if (c) begin ns = 3'd3; mLv = mLv - 3'd1; end else if (p) ns = 3'd5;
      3'd3: if (tk && mCnt == 8'(CRASHF - 1)) ns = (mLv == 3'd0) ? 3'd4 : 3'd2;
      3'd5: if (p) ns = 3'd2;
      default: ;
    endcase
    if (ns != mSt) nc = 8'd0;
    mSt = ns;
    mCnt = nc;
  endtask

  task automatic step(input bit tk, input bit s, input bit c, input bit p, input bit r);
    exp_t e;
    tick = tk; start = s; crash = c; rst = r;
`ifdef DSEQ_PAUSE_EN
    pause = p;
`endif
    modelStep(tk, s, c, p, r);
    e.st = 8'(mSt); e.sel = modelSel(); e.rnd = mLfsr; e.lv = 8'(mLv);
    e.play = (mSt == 3'd2) ? 8'd1 : 8'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; crash = 1'b0; rst = 1'b0;
`ifdef DSEQ_PAUSE_EN
    pause = 1'b0;
`endif
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("state", 8'(st), e.st);
      chk("select", sel, e.sel);
      chk("random", rnd, e.rnd);
      chk("lives", 8'(lv), e.lv);
      chk("playing", 8'(play), e.play);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  logic [7:0] held;

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; crash = 1'b0;
`ifdef DSEQ_PAUSE_EN
    pause = 1'b0;
`endif
    step(0, 0, 0, 0, 1);
    chk("reset_state", 8'(st), 8'd0);
    chk("reset_select", sel, 8'd2);
    chk("reset_random", rnd, 8'hA5);
    chk("reset_lives", 8'(lv), 8'd3);
    chk("reset_playing", 8'(play), 8'd0);

    step(1, 0, 0, 0, 0); chk("lfsr_1", rnd, 8'h4A);
    step(1, 0, 0, 0, 0); chk("lfsr_2", rnd, 8'h95);
    step(1, 0, 0, 0, 0); chk("lfsr_3", rnd, 8'h2A);

    // Ignored crash in ATTRACT, then a held start pulse
    step(0, 0, 1, 0, 0); chk("attract_crash_ign", 8'(st), 8'd0);
    step(0, 1, 0, 0, 0); chk("start_ready", 8'(st), 8'd1);
    step(0, 1, 0, 0, 0); chk("start_held_ign", 8'(st), 8'd1);
    step(0, 0, 1, 0, 0); chk("ready_crash_ign", sel, 8'd1);
    ticks(3);            chk("ready_select", sel, 8'd1);
    ticks(1);
    chk("play_state", 8'(st), 8'd2);
    chk("play_select", sel, 8'd0);
    chk("play_flag", 8'(play), 8'd1);

    step(0, 1, 0, 0, 0); chk("play_start_ign", 8'(st), 8'd2);
    step(0, 0, 1, 0, 0);
    chk("crash_lives", 8'(lv), 8'd2);
    chk("crash_select0", sel, 8'd1);
    for (int k = 1; k <= CRASHF; k++) begin
      step(1, 0, 0, 0, 0);
      if (k < CRASHF) chk("flash_select", sel, (k % 2 == 0) ? 8'd1 : 8'd0);
    end
    chk("flash_to_play", 8'(st), 8'd2);

    for (int n = 0; n < 2; n++) begin
      step(0, 0, 1, 0, 0);
      ticks(CRASHF);
    end
    chk("over_state", 8'(st), 8'd4);
    chk("over_select", sel, 8'd1);
    chk("over_lives", 8'(lv), 8'd0);
    step(0, 0, 1, 0, 0); chk("over_crash_ign", 8'(st), 8'd4);
    step(0, 1, 0, 0, 0);
    chk("restart_state", 8'(st), 8'd1);
    chk("restart_lives", 8'(lv), 8'd3);

    ticks(READYF);
    step(1, 0, 1, 0, 0);
    chk("crash_tick_state", 8'(st), 8'd3);
    chk("crash_tick_sel", sel, 8'd1);
    ticks(2);
    step(1, 1, 1, 0, 1);
    chk("midreset_state", 8'(st), 8'd0);
    chk("midreset_select", sel, 8'd2);
    chk("midreset_random", rnd, 8'hA5);
    chk("midreset_lives", 8'(lv), 8'd3);
    step(0, 0, 0, 0, 0);

    step(1, 1, 0, 0, 0);
    chk("start_tick_state", 8'(st), 8'd1);
    chk("start_tick_lfsr", rnd, 8'h4A);

`ifdef DSEQ_PAUSE_EN
    ticks(READYF);
    step(0, 0, 0, 1, 0); chk("pause_enter", 8'(st), 8'd5);
    held = rnd;
    ticks(5);
    chk("pause_state_hold", 8'(st), 8'd5);
    chk("pause_lfsr_hold", rnd, held);
    step(0, 0, 1, 0, 0); chk("pause_crash_ign", 8'(st), 8'd5);
    step(0, 0, 0, 1, 0); chk("pause_exit", 8'(st), 8'd2);
    step(0, 0, 1, 1, 0); chk("pause_crash_win", 8'(st), 8'd3);
`else
    held = 8'd0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
